counter_ctrl: RTL

Sequencer for the up/down loadable `counter`. On a `start` command it loads a start value, runs the counter toward its terminal value (all-ones counting up, zero counting down) and reloads automatically for a programmed number of periods. It signals each terminal hit and the end of the run, and supports pause and abort. It sits between the software/register front end and the counter datapath, and owns the counter's `load_n`, `ce`, `up_down` and `data_load` pins.

---
 rtl/counter_ctrl_pkg.sv | 13 +
 rtl/counter_ctrl_if.sv | 27 ++
 rtl/counter_ctrl_counter.sv | 26 ++
 rtl/counter_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter sequencer and its counter datapath.
package counter_package;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, DONE} ctrl_state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic logic is_busy(input ctrl_state_e s);
    return s inside {LOAD, RUN, PAUSE};
  endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Command/status bundle between the register front end (master) and counter_ctrl (slave).
interface counter_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int PER_W = 4
);
  logic             start;
  logic             abort;
  logic             pause;
  logic             dir;
  logic [WIDTH-1:0] init_val;
  logic [PER_W-1:0] periods;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             period_tick;
  logic [PER_W-1:0] periods_left;

  modport master (
    output start, abort, pause, dir, init_val, periods,
    input  count, busy, done, period_tick, periods_left
  );

  modport slave (
    input  start, abort, pause, dir, init_val, periods,
    output count, busy, done, period_tick, periods_left
  );
endinterface

// File: rtl/counter_ctrl_counter.sv
// Up/down loadable counter; synchronous load has priority over count enable.
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_n,
  input  logic             ce,
  input  logic             up_down,
  input  logic [WIDTH-1:0] data_load,
  output logic [WIDTH-1:0] count_out,
  output logic             max_count,
  output logic             zero
);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       count_out <= '0;
    else if (!load_n) count_out <= data_load;
    else if (ce)      count_out <= up_down ? count_out + 1'b1 : count_out - 1'b1;
  end

  assign max_count = &count_out;
  assign zero      = ~|count_out;

endmodule

// File: rtl/counter_ctrl.sv
// Run sequencer: loads init_val, counts to the terminal value, reloads for the
// programmed number of periods and reports ticks, completion, pause and abort.
module counter_ctrl
  import counter_package::*;
#(
  parameter int WIDTH = 4,
  parameter int PER_W = 4
) (
  input logic           clk,
  input logic           rst_n,
  counter_ctrl_if.slave bus
);

  ctrl_state_e      state, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] init_q, init_d;
  logic [PER_W-1:0] periods_left, periods_left_d;

  logic             load_n, ce;
  logic [WIDTH-1:0] count_w;
  logic             max_count, zero;
  logic             terminal, accept;

  counter #(.WIDTH(WIDTH)) u_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_n    (load_n),
    .ce        (ce),
    .up_down   (dir_q),
    .data_load (init_q),
    .count_out (count_w),
    .max_count (max_count),
    .zero      (zero)
  );

  assign terminal = (dir_q == DIR_UP) ? max_count : zero;
  assign accept   = bus.start & ~bus.abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dir_q        <= DIR_DOWN;
      init_q       <= '0;
      periods_left <= '0;
    end else begin
      state        <= state_d;
      dir_q        <= dir_d;
      init_q       <= init_d;
      periods_left <= periods_left_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default up front so no path leaves it unassigned (no latch).
    state_d        = state;
    dir_d          = dir_q;
    init_d         = init_q;
    periods_left_d = periods_left;

    unique case (state)
      IDLE, DONE: begin
        state_d = (state == DONE) ? IDLE : state;
        if (accept) begin
          dir_d          = bus.dir;
          init_d         = bus.init_val;
          periods_left_d = bus.periods;
          state_d        = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (bus.pause) begin
          state_d = PAUSE;
        end else if (terminal) begin
          if (periods_left == PER_W'(1)) begin
            state_d = DONE;
          end else begin
            // Continuous mode (periods_left == 0) reloads forever without counting down.
            if (periods_left != '0) periods_left_d = periods_left - 1'b1;
            state_d = LOAD;
          end
        end
      end
      PAUSE: if (!bus.pause) state_d = RUN;
      default: state_d = IDLE;
    endcase

    if (bus.abort && state != IDLE) begin
      state_d        = IDLE;
      periods_left_d = '0;
    end
  end

  always_comb begin
    load_n          = 1'b1;
    ce              = 1'b0;
    bus.period_tick = 1'b0;
    case (state)
      LOAD: load_n = 1'b0;
      RUN: begin
        if (!bus.abort && !bus.pause) begin
          if (terminal) bus.period_tick = 1'b1;
          else          ce              = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.busy         = is_busy(state);
  assign bus.done         = (state == DONE);
  assign bus.count        = count_w;
  assign bus.periods_left = periods_left;

endmodule
